// File: rtl/bcd_display_arbiter.sv
// ---------------------------------------------------------------------------
// bcd_display_arbiter
//
// Shares one two-digit decimal display path (tens z, ones B) between NREQ
// 4-bit requesters. A round-robin arbiter grants one requester at a time.
// The design captures that requester's value and holds it on the display for
// HOLD cycles, or until the requester drops its request. It then releases
// the display and re-arbitrates.
//
// Ports
//   Clock      system clock, all state on the rising edge
//   Resetn     asynchronous active-low reset
//   req        level-sensitive request lines, one per requester
//   data       requester values, requester i on data[4i+3:4i]
//   grant      one-hot grant (registered)
//   busy       high whenever the sequencer is not idle (registered)
//   active_id  index of the current or most recently granted requester
//   V          captured binary value (registered)
//   z          tens digit, 1 when V >= 10 (registered)
//   B          ones digit in BCD (registered)
// ---------------------------------------------------------------------------
module bcd_display_arbiter #(
    parameter int NREQ = 4,
    parameter int HOLD = 50000000,
    parameter int CW   = 26
) (
    input  logic [0:0]        Clock,
    input  logic [0:0]        Resetn,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] data,
    output logic [NREQ-1:0]   grant,
    output logic [0:0]        busy,
    output logic [2:0]        active_id,
    output logic [3:0]        V,
    output logic [0:0]        z,
    output logic [3:0]        B
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_SHOW    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          state_q;
    logic [NREQ-1:0] grant_q;
    logic            busy_q;
    logic [2:0]      active_id_q;
    logic [2:0]      ptr_q;
    logic [3:0]      v_q;
    logic            z_q;
    logic [3:0]      b_q;
    logic [CW-1:0]   cnt_q;

    // Per-requester value slices
    logic [3:0] data_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign data_arr[gi] = data[4*gi +: 4];
        end
    endgenerate

    // Round-robin search. The request vector is rotated so that bit 0 is the
    // requester at ptr. The lowest set bit of the rotated vector is then the
    // winner's offset from ptr.
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [2:0]        win_off_d;
    logic [3:0]        win_sum_d;
    logic [2:0]        winner_d;

    always_comb begin
        req_dbl   = {req, req} >> ptr_q;
        req_rot   = req_dbl[NREQ-1:0];
        win_off_d = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off_d = 3'(k);
            end
        end
        win_sum_d = {1'b0, ptr_q} + {1'b0, win_off_d};
        if (win_sum_d >= 4'(NREQ)) begin
            win_sum_d = win_sum_d - 4'(NREQ);
        end
        winner_d = win_sum_d[2:0];
    end

    // Select the active requester's value and request line, and compute the
    // pointer that follows it.
    logic [3:0] cap_d;
    logic       req_cur_d;
    logic [2:0] ptr_d;
    logic       z_d;
    logic [3:0] b_d;

    always_comb begin
        cap_d     = '0;
        req_cur_d = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (active_id_q == 3'(i)) begin
                cap_d     = data_arr[i];
                req_cur_d = req[i];
            end
        end
        ptr_d = (active_id_q == 3'(NREQ - 1)) ? 3'd0 : active_id_q + 3'd1;
        z_d   = (cap_d >= 4'd10);
        b_d   = z_d ? cap_d - 4'd10 : cap_d;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            active_id_q <= '0;
            ptr_q       <= '0;
            v_q         <= '0;
            z_q         <= 1'b0;
            b_q         <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        grant_q     <= NREQ'(1) << winner_d;
                        active_id_q <= winner_d;
                        busy_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Only this cycle's sample reaches the display.
                    v_q     <= cap_d;
                    z_q     <= z_d;
                    b_q     <= b_d;
                    cnt_q   <= '0;
                    state_q <= S_SHOW;
                end
                S_SHOW: begin
                    cnt_q <= cnt_q + CW'(1);
                    if ((cnt_q == CW'(HOLD - 1)) || !req_cur_d) begin
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    grant_q <= '0;
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign active_id = active_id_q;
    assign V         = v_q;
    assign z         = z_q;
    assign B         = b_q;

endmodule

// File: tb/tb_bcd_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_arbiter
//
// Drives directed scenarios followed by random request/data traffic. Every
// cycle, all DUT outputs are compared against a reference model. The model
// tracks the current owner, the dwell progress and the rotating pointer as
// plain integers, and derives the decimal digits with division arithmetic.
// ---------------------------------------------------------------------------
module tb_bcd_display_arbiter;

    localparam int NREQ = 4;
    localparam int HOLD = 4;
    localparam int CW   = 4;

    logic              Clock = 1'b0;
    logic              Resetn;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] data;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [2:0]        active_id;
    logic [3:0]        V;
    logic              z;
    logic [3:0]        B;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_owner;   // -1 when no requester holds the display
    int m_last;    // last granted requester
    int m_age;     // 0: capture pending, 1..HOLD: dwell cycle number
    bit m_rel;     // dwell finished, release cycle in progress
    int m_ptr;     // first requester searched next
    int m_val;     // value on the display

    bcd_display_arbiter #(
        .NREQ(NREQ),
        .HOLD(HOLD),
        .CW  (CW)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .req      (req),
        .data     (data),
        .grant    (grant),
        .busy     (busy),
        .active_id(active_id),
        .V        (V),
        .z        (z),
        .B        (B)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit req_bit(input int idx);
        return ((req >> idx) & 4'b0001) != 4'b0000;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_age   = 0;
        m_rel   = 1'b0;
        m_ptr   = 0;
        m_val   = 0;
    endtask

    task automatic model_step();
        int idx;
        bit found;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!found && req_bit(idx)) begin
                    found   = 1'b1;
                    m_owner = idx;
                    m_last  = idx;
                    m_age   = 0;
                    m_rel   = 1'b0;
                    $display("txn: grant to requester %0d at %0t", idx, $time);
                end
            end
        end else if (m_rel) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
        end else if (m_age == 0) begin
            m_val = int'((data >> (4 * m_owner)) & 16'h000F);
            m_age = 1;
        end else begin
            if (m_age == HOLD || !req_bit(m_owner)) begin
                m_rel = 1'b1;
            end else begin
                m_age++;
            end
        end
    endtask

    always @(posedge Clock) begin
        if (Resetn) begin
            model_step();
        end
    end

    task automatic check_all();
        check_eq("grant", 32'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
        check_eq("busy", 32'(busy), (m_owner >= 0) ? 1 : 0);
        check_eq("active_id", 32'(active_id), m_last);
        check_eq("V", 32'(V), m_val);
        check_eq("z", 32'(z), m_val / 10);
        check_eq("B", 32'(B), m_val % 10);
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
        check_all();
    endtask

    task automatic wait_grant(input int id);
        int n = 0;
        while (((grant >> id) & 4'b0001) == 4'b0000 && n < 20) begin
            step();
            n++;
        end
        check_eq("wait_grant", 32'((grant >> id) & 4'b0001), 1);
    endtask

    initial begin
        Resetn = 1'b0;
        req    = '0;
        data   = '0;
        model_reset();
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check_all();
        Resetn = 1'b1;

        // Idle with no requests
        repeat (10) step();

        // Sole requester 0 with value 13, re-granted through IDLE
        req  = 4'b0001;
        data = 16'h000D;
        repeat (20) step();

        // All requesting: values 15, 9, 10, 4 for requesters 0..3
        req  = 4'b1111;
        data = 16'h4A9F;
        repeat (30) step();

        // Requester 2 shows 7; a change to 12 during the dwell is not displayed
        req  = 4'b0100;
        data = 16'h0700;
        wait_grant(2);
        step();
        step();
        data = 16'h0C00;
        repeat (8) step();

        // Requester 1 drops after one dwell cycle; pending requester 2 wins next
        req = 4'b0010;
        wait_grant(1);
        step();
        step();
        req = 4'b0100;
        repeat (8) step();

        // Asynchronous reset in the middle of the dwell
        req  = 4'b0001;
        data = 16'h0003;
        wait_grant(0);
        step();
        step();
        @(posedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        check_eq("rst_grant", 32'(grant), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_V", 32'(V), 0);
        check_eq("rst_z", 32'(z), 0);
        check_eq("rst_B", 32'(B), 0);
        check_eq("rst_active_id", 32'(active_id), 0);
        model_reset();
        @(negedge Clock);
        req    = 4'b1001;
        Resetn = 1'b1;
        step();
        check_eq("rr_after_reset", 32'(grant), 1);
        repeat (10) step();

        // Random traffic
        repeat (600) begin
            if ($urandom_range(0, 5) == 0) begin
                req = NREQ'($urandom);
            end
            data = 16'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
